mem_access_unit: RTL and testbench

//  MEM-stage responder for the EX->MEM interconnection_struct packet. Executes loads/stores on a
//  64-bit data-memory req/gnt/rvalid bus, aligns and extends load data into rf_wr_data, and issues
//  one registered packet per instruction to WB. Stalls upstream while an access is in flight.

---
 rtl/mem_access_unit_pkg.sv | 57 +++++
 rtl/mem_access_unit_if.sv | 31 +++
 rtl/mem_load_align.sv | 31 +++
 rtl/mem_access_unit.sv | 132 +++++++++++++
 tb/tb_mem_access_unit.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage access unit.
//   interconnection_struct : EX->MEM->WB pipeline packet
//   mau_state_t            : access FSM states
//   MEM_UNIT_*             : one-hot access size codes carried in mem_req_unit
//   unit_* helpers         : size decode used by the legality check and store lane steering
package mem_access_unit_pkg;

    localparam int unsigned DMEM_DATA_W = 64;

    localparam logic [3:0] MEM_UNIT_B = 4'b0001;
    localparam logic [3:0] MEM_UNIT_H = 4'b0010;
    localparam logic [3:0] MEM_UNIT_W = 4'b0100;
    localparam logic [3:0] MEM_UNIT_D = 4'b1000;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} mau_state_t;

    typedef struct packed {
        logic        is_valid;
        logic [63:0] pc;
        logic [63:0] alu_result;    // effective address for loads/stores
        logic        mem_rd;
        logic        mem_wr;
        logic        mem_wr_en;
        logic [3:0]  mem_req_unit;
        logic        mem_ext;
        logic [63:0] mem_data;
        logic        rf_wr;
        logic [4:0]  rf_wr_addr;
        logic [63:0] rf_wr_data;
    } interconnection_struct;

    function automatic logic unit_onehot(input logic [3:0] unit);
        return unit inside {MEM_UNIT_B, MEM_UNIT_H, MEM_UNIT_W, MEM_UNIT_D};
    endfunction

    function automatic logic unit_aligned(input logic [3:0] unit, input logic [2:0] off);
        case (unit)
            MEM_UNIT_B: return 1'b1;
            MEM_UNIT_H: return off[0] == 1'b0;
            MEM_UNIT_W: return off[1:0] == 2'b00;
            MEM_UNIT_D: return off == 3'b000;
            default:    return 1'b0;
        endcase
    endfunction

    // Byte-enable pattern of an access before it is shifted to its lane.
    function automatic logic [7:0] unit_be_base(input logic [3:0] unit);
        case (unit)
            MEM_UNIT_B: return 8'h01;
            MEM_UNIT_H: return 8'h03;
            MEM_UNIT_W: return 8'h0F;
            MEM_UNIT_D: return 8'hFF;
            default:    return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/gnt/rvalid bus.
//   req/we/be/addr/wdata : request side, driven by the master (the access unit)
//   gnt                  : request accepted this cycle
//   rvalid/rdata         : load response, earliest the cycle after gnt
interface mem_access_unit_if
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = DMEM_DATA_W
) ();

    logic              req;
    logic              we;
    logic [7:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_load_align.sv
// Combinational load-data alignment.
//   rdata   : 64-bit word returned by memory
//   addr_lo : byte offset of the access within the word
//   unit    : one-hot access size (B/H/W/D)
//   ext     : 1 = sign-extend, 0 = zero-extend
//   result  : aligned, extended value for the register file
module mem_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  addr_lo,
    input  logic [3:0]  unit,
    input  logic        ext,
    output logic [63:0] result
);

    logic [63:0] shifted;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        result  = shifted;
        unique case (unit)
            MEM_UNIT_B: result = {{56{ext & shifted[7]}},  shifted[7:0]};
            MEM_UNIT_H: result = {{48{ext & shifted[15]}}, shifted[15:0]};
            MEM_UNIT_W: result = {{32{ext & shifted[31]}}, shifted[31:0]};
            MEM_UNIT_D: result = shifted;
            default:    result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: executes loads/stores on the data-memory bus and forwards one
// registered packet per instruction to WB.
//   clk, rst  : clock, synchronous active-high reset
//   ex_pkt_i  : packet from EX, held stable while stall_o=1
//   wb_pkt_o  : registered packet to WB (load data merged into rf_wr_data)
//   stall_o   : an access is in flight; upstream must hold
//   err_o     : one-cycle pulse for a misaligned or malformed access
//   dmem      : data-memory bus (master side)
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  interconnection_struct ex_pkt_i,
    output interconnection_struct wb_pkt_o,
    output logic                  stall_o,
    output logic                  err_o,
    mem_access_unit_if.master     dmem
);

    mau_state_t            state_q, state_d;
    interconnection_struct hold_q, hold_d;
    interconnection_struct wb_q, wb_d;
    logic                  err_q, err_d;

    logic [2:0]        ex_off;
    logic              ex_is_mem;
    logic              ex_illegal;
    logic [2:0]        hold_off;
    logic [63:0]       load_data;
    logic [DATA_W-1:0] store_lanes;

    assign ex_off    = ex_pkt_i.alu_result[2:0];
    assign ex_is_mem = ex_pkt_i.mem_rd | ex_pkt_i.mem_wr;
    assign ex_illegal = ex_is_mem &
                        ((ex_pkt_i.mem_rd & ex_pkt_i.mem_wr) |
                         ~unit_onehot(ex_pkt_i.mem_req_unit) |
                         ~unit_aligned(ex_pkt_i.mem_req_unit, ex_off));

    assign hold_off    = hold_q.alu_result[2:0];
    assign store_lanes = hold_q.mem_data << {hold_off, 3'b000};

    mem_load_align u_load_align (
        .rdata   (dmem.rdata),
        .addr_lo (hold_off),
        .unit    (hold_q.mem_req_unit),
        .ext     (hold_q.mem_ext),
        .result  (load_data)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        wb_d    = '0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ex_pkt_i.is_valid) begin
                    if (!ex_is_mem) begin
                        wb_d = ex_pkt_i;
                    end else if (ex_illegal) begin
                        // Retire without a bus access and suppress the register write.
                        wb_d       = ex_pkt_i;
                        wb_d.rf_wr = 1'b0;
                        err_d      = 1'b1;
                    end else begin
                        hold_d  = ex_pkt_i;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem.gnt) begin
                    if (hold_q.mem_wr) begin
                        wb_d    = hold_q;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem.rvalid) begin
                    wb_d            = hold_q;
                    wb_d.rf_wr_data = load_data;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus request fields come only from the hold register so they stay stable until gnt.
    always_comb begin
        dmem.req   = 1'b0;
        dmem.we    = 1'b0;
        dmem.be    = 8'h00;
        dmem.addr  = '0;
        dmem.wdata = '0;
        if (state_q == REQ) begin
            dmem.req  = 1'b1;
            dmem.we   = hold_q.mem_wr;
            dmem.addr = {hold_q.alu_result[ADDR_W-1:3], 3'b000};
            if (hold_q.mem_wr) begin
                dmem.be    = unit_be_base(hold_q.mem_req_unit) << hold_off;
                dmem.wdata = store_lanes;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            wb_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            wb_q    <= wb_d;
            err_q   <= err_d;
        end
    end

    assign wb_pkt_o = wb_q;
    assign err_o    = err_q;
    assign stall_o  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    interconnection_struct ex_pkt;
    interconnection_struct wb_pkt;
    logic                  stall;
    logic                  err;

    mem_access_unit_if dmem_if ();

    mem_access_unit dut (
        .clk      (clk),
        .rst      (rst),
        .ex_pkt_i (ex_pkt),
        .wb_pkt_o (wb_pkt),
        .stall_o  (stall),
        .err_o    (err),
        .dmem     (dmem_if)
    );

    typedef struct {
        interconnection_struct pkt;
        bit                    err;
        bit                    mem;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    // Expected state of the single outstanding access, if any.
    bit          cur_active = 1'b0;
    bit          cur_we;
    logic [63:0] cur_addr;
    logic [63:0] cur_wdata;
    logic [7:0]  cur_be;
    bit          chk_en = 1'b0;

    // Memory responder knobs and observations.
    bit          rand_mode   = 1'b0;
    int          gnt_delay_k = 0;
    int          rv_delay_k  = 1;
    logic [63:0] mem [16];
    logic [7:0]  last_be;
    logic [63:0] last_waddr;
    logic [63:0] last_wdata;

    task automatic chk(input string name, input logic [383:0] got, input logic [383:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    function automatic int unit_bytes(input logic [3:0] u);
        case (u)
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0100: return 4;
            4'b1000: return 8;
            default: return 0;
        endcase
    endfunction

    // Byte-wise extraction from the memory image, then extension.
    function automatic logic [63:0] model_load(input logic [63:0] a, input int n, input bit ext);
        logic [63:0] w;
        logic [63:0] v;
        int          off;
        w   = mem[a[6:3]];
        off = int'(a % 8);
        v   = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
        if (ext && n < 8 && v[8*n-1]) begin
            for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_accept(input interconnection_struct p);
        exp_t e;
        int   n;
        int   off;
        if (!p.is_valid) return;
        n     = unit_bytes(p.mem_req_unit);
        off   = int'(p.alu_result % 8);
        e.pkt = p;
        e.err = 1'b0;
        e.mem = 1'b0;
        if (p.mem_rd || p.mem_wr) begin
            if ((p.mem_rd && p.mem_wr) || n == 0 || (off % n) != 0) begin
                e.pkt.rf_wr = 1'b0;
                e.err       = 1'b1;
            end else begin
                e.mem      = 1'b1;
                cur_active = 1'b1;
                cur_we     = p.mem_wr;
                cur_addr   = p.alu_result - 64'(off);
                cur_be     = p.mem_wr ? 8'(((1 << n) - 1) << off) : 8'h00;
                cur_wdata  = p.mem_data << (8 * off);
                if (p.mem_rd) e.pkt.rf_wr_data = model_load(p.alu_result, n, p.mem_ext);
            end
        end
        exp_q.push_back(e);
    endtask

    // Present a packet until the unit accepts it (stall low at the sampling edge).
    task automatic send(input interconnection_struct p);
        bit acc;
        int guard;
        acc    = 1'b0;
        guard  = 0;
        ex_pkt = p;
        while (!acc) begin
            @(negedge clk);
            acc = (stall == 1'b0);
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 60) begin
                chk("accept_timeout", stall, 1'b0);
                $fatal(1, "accept timeout");
            end
        end
        model_accept(p);
        ex_pkt = '0;
    endtask

    task automatic wait_wb(output int lat, output interconnection_struct got, output logic got_err);
        lat     = 0;
        got     = '0;
        got_err = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (wb_pkt.is_valid) begin
                lat     = i;
                got     = wb_pkt;
                got_err = err;
                break;
            end
        end
        if (lat == 0) chk("wb_timeout", wb_pkt.is_valid, 1'b1);
        @(posedge clk);
        #1;
    endtask

    function automatic interconnection_struct mk_pkt(input bit rd, input bit wr,
                                                     input logic [3:0] unit, input bit ext,
                                                     input logic [63:0] addr,
                                                     input logic [63:0] data);
        interconnection_struct p;
        p              = '0;
        p.is_valid     = 1'b1;
        p.pc           = 64'h100;
        p.alu_result   = addr;
        p.mem_rd       = rd;
        p.mem_wr       = wr;
        p.mem_wr_en    = wr;
        p.mem_req_unit = unit;
        p.mem_ext      = ext;
        p.mem_data     = data;
        p.rf_wr        = 1'b1;
        p.rf_wr_addr   = 5'd7;
        p.rf_wr_data   = 64'hDEAD_BEEF;
        return p;
    endfunction

    function automatic interconnection_struct rand_pkt();
        interconnection_struct p;
        int                    k;
        int                    n;
        logic [3:0]            u;
        logic [63:0]           a;
        k = $urandom_range(0, 9);
        if ($urandom_range(0, 9) != 0) u = 4'(4'b0001 << $urandom_range(0, 3));
        else                           u = 4'($urandom_range(0, 15));
        a = 64'h4000 + 64'($urandom_range(0, 127));
        n = unit_bytes(u);
        if (n > 0 && $urandom_range(0, 4) != 0) a = a - (a % 64'(n));
        p              = '0;
        p.is_valid     = (k != 0);
        p.pc           = {$urandom, $urandom};
        p.alu_result   = a;
        p.mem_rd       = (k >= 4 && k <= 6) || k == 9;
        p.mem_wr       = (k >= 7);
        p.mem_wr_en    = 1'($urandom_range(0, 1));
        p.mem_req_unit = u;
        p.mem_ext      = 1'($urandom_range(0, 1));
        p.mem_data     = {$urandom, $urandom};
        p.rf_wr        = 1'($urandom_range(0, 1));
        p.rf_wr_addr   = 5'($urandom_range(0, 31));
        p.rf_wr_data   = {$urandom, $urandom};
        return p;
    endfunction

    // Memory responder: grants after a delay, returns load data, applies stores,
    // and injects stray rvalid pulses in random mode.
    initial begin
        int          wcnt;
        int          rvcnt;
        bit          counting;
        logic [63:0] pend;
        wcnt     = 0;
        rvcnt    = 0;
        counting = 1'b0;
        pend     = '0;
        for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
        dmem_if.gnt    = 1'b0;
        dmem_if.rvalid = 1'b0;
        dmem_if.rdata  = '0;
        forever begin
            @(negedge clk);
            dmem_if.gnt    = 1'b0;
            dmem_if.rvalid = 1'b0;
            dmem_if.rdata  = {$urandom, $urandom};
            if (rvcnt > 0) begin
                rvcnt--;
                if (rvcnt == 0) begin
                    dmem_if.rvalid = 1'b1;
                    dmem_if.rdata  = pend;
                end
            end else if (dmem_if.req) begin
                if (!counting) begin
                    counting = 1'b1;
                    wcnt     = rand_mode ? int'($urandom_range(0, 3)) : gnt_delay_k;
                end
                if (wcnt == 0) begin
                    counting    = 1'b0;
                    dmem_if.gnt = 1'b1;
                    if (dmem_if.we) begin
                        for (int b = 0; b < 8; b++) begin
                            if (dmem_if.be[b]) mem[dmem_if.addr[6:3]][8*b +: 8] = dmem_if.wdata[8*b +: 8];
                        end
                        last_be    = dmem_if.be;
                        last_waddr = dmem_if.addr;
                        last_wdata = dmem_if.wdata;
                    end else begin
                        pend  = mem[dmem_if.addr[6:3]];
                        rvcnt = rand_mode ? int'($urandom_range(1, 3)) : rv_delay_k;
                    end
                end else begin
                    wcnt--;
                end
            end else if (rand_mode && $urandom_range(0, 3) == 0) begin
                dmem_if.rvalid = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (wb_pkt.is_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("wb_unexpected_valid", wb_pkt.is_valid, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wb_pkt", wb_pkt, e.pkt);
                        chk("err_o", err, e.err);
                        if (e.mem) cur_active = 1'b0;
                    end
                end else begin
                    chk("err_o_idle", err, 1'b0);
                end
                chk("stall_o", stall, cur_active);
                if (cur_active) begin
                    if (dmem_if.req) begin
                        chk("dmem_we", dmem_if.we, cur_we);
                        chk("dmem_addr", dmem_if.addr, cur_addr);
                        chk("dmem_be", dmem_if.be, cur_be);
                        if (cur_we) chk("dmem_wdata", dmem_if.wdata, cur_wdata);
                    end
                end else begin
                    chk("dmem_req_idle", dmem_if.req, 1'b0);
                end
            end
        end
    end

    initial begin
        interconnection_struct p;
        interconnection_struct got;
        logic                  got_err;
        int                    lat;
        int                    extra;
        ex_pkt = '0;
        rst    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        chk("rst_wb_pkt", wb_pkt, '0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_req", dmem_if.req, 1'b0);
        chk("rst_we", dmem_if.we, 1'b0);
        chk("rst_be", dmem_if.be, 8'h00);
        chk_en = 1'b1;

        // ALU pass-through.
        p = mk_pkt(1'b0, 1'b0, 4'b0000, 1'b0, 64'h55, 64'h0);
        p.rf_wr_data = 64'h1234;
        send(p);
        wait_wb(lat, got, got_err);
        chk("t1_latency", lat, 1);
        chk("t1_data", got.rf_wr_data, 64'h1234);

        // Store byte into lane 3.
        gnt_delay_k = 0;
        send(mk_pkt(1'b0, 1'b1, MEM_UNIT_B, 1'b0, 64'h1003, 64'hAB));
        wait_wb(lat, got, got_err);
        chk("t2_latency", lat, 2);
        chk("t2_be", last_be, 8'h08);
        chk("t2_addr", last_waddr, 64'h1000);
        chk("t2_wdata_lane", last_wdata[31:24], 8'hAB);

        // Seed a doubleword, then read a signed/unsigned half from its top lanes.
        rv_delay_k = 1;
        send(mk_pkt(1'b0, 1'b1, MEM_UNIT_D, 1'b0, 64'h2000, 64'h8001_0000_0000_0000));
        wait_wb(lat, got, got_err);
        send(mk_pkt(1'b1, 1'b0, MEM_UNIT_H, 1'b1, 64'h2006, 64'h0));
        wait_wb(lat, got, got_err);
        chk("t3_latency", lat, 3);
        chk("t3_signed", got.rf_wr_data, 64'hFFFF_FFFF_FFFF_8001);
        send(mk_pkt(1'b1, 1'b0, MEM_UNIT_H, 1'b0, 64'h2006, 64'h0));
        wait_wb(lat, got, got_err);
        chk("t3_unsigned", got.rf_wr_data, 64'h8001);

        // Word load with a slow grant and slow data.
        gnt_delay_k = 3;
        rv_delay_k  = 2;
        send(mk_pkt(1'b1, 1'b0, MEM_UNIT_W, 1'b1, 64'h2004, 64'h0));
        wait_wb(lat, got, got_err);
        chk("t4_latency", lat, 7);
        chk("t4_data", got.rf_wr_data, 64'hFFFF_FFFF_8001_0000);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (wb_pkt.is_valid) extra++;
        end
        chk("t4_single_wb", extra, 0);
        @(posedge clk);
        #1;

        // Misaligned doubleword load.
        send(mk_pkt(1'b1, 1'b0, MEM_UNIT_D, 1'b0, 64'h3004, 64'h0));
        wait_wb(lat, got, got_err);
        chk("t5_latency", lat, 1);
        chk("t5_err", got_err, 1'b1);
        chk("t5_rf_wr", got.rf_wr, 1'b0);

        // Reset while waiting for load data; the stale rvalid lands afterwards.
        gnt_delay_k = 0;
        rv_delay_k  = 2;
        send(mk_pkt(1'b1, 1'b0, MEM_UNIT_D, 1'b0, 64'h2000, 64'h0));
        @(posedge clk);
        #1;
        chk("t6_in_wait", stall, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        cur_active = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t6_wb_zero", wb_pkt, '0);
        end
        @(posedge clk);
        #1;
        p = mk_pkt(1'b0, 1'b0, 4'b0000, 1'b0, 64'h77, 64'h0);
        p.rf_wr_data = 64'hCAFE;
        send(p);
        wait_wb(lat, got, got_err);
        chk("t6_after_latency", lat, 1);
        chk("t6_after_data", got.rf_wr_data, 64'hCAFE);

        // Randomized stream against the model.
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) send(rand_pkt());
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !cur_active) break;
            @(posedge clk);
            #1;
        end
        chk("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
